// File: rtl/irq_controller.sv
// irq_controller
//   Synchronises the external interrupt lines and latches their rising edges
//   as pending requests. Arbitrates them by fixed priority, where the highest
//   index wins and only sources above the current handler level may nest.
//   Offers one request at a time to the CPU using a req/ack handshake, and
//   tracks which handlers are in service until ERET.
// Ports
//   clk, rst     clock; asynchronous active-high reset
//   irq_type     raw asynchronous interrupt lines
//   int_en       global interrupt enable from the CPU status register
//   irq_ack      pulse: CPU took the request (EPC saved)
//   eret         pulse: CPU returned from a handler
//   irq_req      request to the CPU
//   irq_id       index of the requested source, frozen while irq_req=1
//   irq_vec      handler address for irq_id, frozen while irq_req=1
//   pending      latched requests that have not been acknowledged yet
//   in_service   acknowledged sources whose handler has not returned
module irq_controller #(
    parameter int          N_IRQ      = 3,
    parameter logic [31:0] VEC_BASE   = 32'h0000_0400,
    parameter logic [31:0] VEC_STRIDE = 32'h0000_0040
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_IRQ-1:0] irq_type,
    input  logic             int_en,
    input  logic             irq_ack,
    input  logic             eret,
    output logic             irq_req,
    output logic [1:0]       irq_id,
    output logic [31:0]      irq_vec,
    output logic [N_IRQ-1:0] pending,
    output logic [N_IRQ-1:0] in_service
);

    typedef enum logic {IDLE, REQ} state_t;

    state_t           state, state_nx;
    logic [N_IRQ-1:0] s1, s2, s3, rise;
    logic             svc_any, cand_vld, grant, ack_fire;
    logic [1:0]       svc_top, cand_id;
    logic [N_IRQ-1:0] eret_clr, ack_set, pending_nx, in_service_nx;

    // s1 is the metastability-catching flop; edge detection starts at s2.
    assign rise    = s2 & ~s3;
    assign irq_req = (state == REQ);

    // Current handler level and the best source allowed to preempt it.
    always_comb begin
        svc_any  = 1'b0;
        svc_top  = '0;
        cand_vld = 1'b0;
        cand_id  = '0;
        for (int i = 0; i < N_IRQ; i++) begin
            if (in_service[i]) begin
                svc_any = 1'b1;
                svc_top = 2'(i);
            end
        end
        for (int i = 0; i < N_IRQ; i++) begin
            if (pending[i] && (!svc_any || 2'(i) > svc_top)) begin
                cand_vld = 1'b1;
                cand_id  = 2'(i);
            end
        end
    end

    // Handshake FSM. A REQ is never re-arbitrated; it ends through an ack, or
    // it is withdrawn when interrupts become disabled.
    always_comb begin
        state_nx = state;
        grant    = 1'b0;
        ack_fire = 1'b0;
        case (state)
            IDLE: begin
                if (int_en && cand_vld) begin
                    state_nx = REQ;
                    grant    = 1'b1;
                end
            end
            REQ: begin
                if (irq_ack) begin
                    ack_fire = 1'b1;
                    state_nx = IDLE;
                end else if (!int_en) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // ERET pops the old top level, and the ack then pushes irq_id. A new rising
    // edge is ORed in last, so it wins over the ack clear of the same source.
    always_comb begin
        eret_clr = '0;
        ack_set  = '0;
        for (int i = 0; i < N_IRQ; i++) begin
            if (eret && svc_any && svc_top == 2'(i)) eret_clr[i] = 1'b1;
            if (ack_fire && irq_id == 2'(i))         ack_set[i]  = 1'b1;
        end
        pending_nx    = (pending & ~ack_set) | rise;
        in_service_nx = (in_service & ~eret_clr) | ack_set;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            s1         <= '0;
            s2         <= '0;
            s3         <= '0;
            pending    <= '0;
            in_service <= '0;
            irq_id     <= '0;
            irq_vec    <= '0;
        end else begin
            state      <= state_nx;
            s1         <= irq_type;
            s2         <= s1;
            s3         <= s2;
            pending    <= pending_nx;
            in_service <= in_service_nx;
            if (grant) begin
                irq_id  <= cand_id;
                irq_vec <= VEC_BASE + 32'(cand_id) * VEC_STRIDE;
            end
        end
    end

endmodule

// File: tb/tb_irq_controller.sv
// tb_irq_controller
//   Directed scenarios and a randomized run against a reference model. The
//   model keeps in_service as a stack of nested handler ids. Every cycle the
//   DUT outputs are compared against this model, and the key points of each
//   scenario are also compared against literal values.
module tb_irq_controller;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  irq_type;
    logic        int_en, irq_ack, eret;
    logic        irq_req;
    logic [1:0]  irq_id;
    logic [31:0] irq_vec;
    logic [2:0]  pending, in_service;

    int total = 0;
    int bad   = 0;

    irq_controller dut (
        .clk(clk), .rst(rst), .irq_type(irq_type), .int_en(int_en),
        .irq_ack(irq_ack), .eret(eret), .irq_req(irq_req), .irq_id(irq_id),
        .irq_vec(irq_vec), .pending(pending), .in_service(in_service)
    );

    always #5 clk = ~clk;

    // reference model state
    bit [2:0] m_s1, m_s2, m_s3, m_pend;
    int       svc_q[$];
    bit       m_req;
    int       m_id;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_s1 = 0; m_s2 = 0; m_s3 = 0; m_pend = 0;
        svc_q.delete();
        m_req = 0; m_id = 0;
    endtask

    function automatic bit [2:0] svc_mask();
        bit [2:0] m = 0;
        foreach (svc_q[k]) m[svc_q[k]] = 1'b1;
        return m;
    endfunction

    task automatic model_step();
        bit [2:0] rise;
        int       floor_lvl, cand;
        bit       ack;
        if (rst) begin
            model_reset();
            return;
        end
        rise      = m_s2 & ~m_s3;
        floor_lvl = (svc_q.size() > 0) ? svc_q[$] : -1;
        cand      = -1;
        for (int i = 0; i < 3; i++)
            if (m_pend[i] && i > floor_lvl) cand = i;
        ack = m_req && irq_ack;
        if (eret && svc_q.size() > 0) void'(svc_q.pop_back());
        if (ack) begin
            svc_q.push_back(m_id);
            m_pend[m_id] = 1'b0;
        end
        m_pend |= rise;
        if (m_req) begin
            if (ack || !int_en) m_req = 0;
        end else if (int_en && cand >= 0) begin
            m_req = 1;
            m_id  = cand;
        end
        m_s3 = m_s2; m_s2 = m_s1; m_s1 = irq_type;
    endtask

    task automatic check_all();
        chk("req", irq_req, m_req);
        if (m_req) begin
            chk("id", irq_id, m_id);
            chk("vec", irq_vec, 32'h400 + m_id * 32'h40);
        end
        chk("pending", pending, m_pend);
        chk("in_service", in_service, svc_mask());
    endtask

    // advance one clock: model follows the edge, compare at the falling edge
    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_all();
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic do_reset();
        rst = 1; irq_type = 0; int_en = 0; irq_ack = 0; eret = 0;
        model_reset();
        ticks(2);
        rst = 0;
    endtask

    task automatic pulse(input logic [2:0] m);
        irq_type = m;
        ticks(3);
        irq_type = 0;
    endtask

    task automatic ack();
        irq_ack = 1; tick(); irq_ack = 0;
    endtask

    task automatic ret();
        eret = 1; tick(); eret = 0;
    endtask

    task automatic wait_req(input int max);
        int n = 0;
        while (!irq_req && n < max) begin
            tick();
            n++;
        end
        chk("req_timeout", irq_req, 1);
    endtask

    initial begin
        int hold = 0;

        // 1: reset with lines 0 and 1 held high
        rst = 1; irq_type = 3'b011; int_en = 1; irq_ack = 0; eret = 0;
        model_reset();
        ticks(2);
        chk("t1_rst_req", irq_req, 0);
        chk("t1_rst_id", irq_id, 0);
        chk("t1_rst_vec", irq_vec, 0);
        chk("t1_rst_pend", pending, 0);
        chk("t1_rst_svc", in_service, 0);
        rst = 0;
        ticks(2);
        chk("t1_pend_early", pending, 3'b000);
        tick();
        chk("t1_pend", pending, 3'b011);
        tick();
        chk("t1_req", irq_req, 1);
        chk("t1_id", irq_id, 1);
        chk("t1_vec", irq_vec, 32'h440);

        // 2: single source 0, ack, eret
        do_reset();
        int_en = 1;
        irq_type = 3'b001;
        wait_req(10);
        tick();
        irq_type = 0;
        chk("t2_id", irq_id, 0);
        chk("t2_vec", irq_vec, 32'h400);
        ack();
        chk("t2_pend", pending, 3'b000);
        chk("t2_svc", in_service, 3'b001);
        chk("t2_req_off", irq_req, 0);
        ret();
        chk("t2_svc_ret", in_service, 3'b000);

        // 3: nesting
        pulse(3'b001); wait_req(10); ack();
        pulse(3'b100); wait_req(10);
        chk("t3_id2", irq_id, 2);
        chk("t3_vec2", irq_vec, 32'h480);
        ack();
        chk("t3_svc", in_service, 3'b101);
        pulse(3'b010); ticks(4);
        chk("t3_no_req", irq_req, 0);
        ret();
        chk("t3_svc_ret", in_service, 3'b001);
        wait_req(10);
        chk("t3_id1", irq_id, 1);

        // 4: simultaneous 1 and 2; 2 first, 1 once the handler of 2 returns
        do_reset();
        int_en = 1;
        pulse(3'b110); wait_req(10);
        chk("t4_id2", irq_id, 2);
        ack();
        chk("t4_req_gap", irq_req, 0);
        ret();
        chk("t4_svc", in_service, 0);
        tick();
        chk("t4_req1", irq_req, 1);
        chk("t4_id1", irq_id, 1);

        // 5: int_en withdraw, re-raise, reset mid-request
        do_reset();
        int_en = 1;
        pulse(3'b001); wait_req(10);
        int_en = 0; tick();
        chk("t5_withdraw", irq_req, 0);
        chk("t5_pend_kept", pending, 3'b001);
        int_en = 1; tick();
        chk("t5_rereq", irq_req, 1);
        chk("t5_id0", irq_id, 0);
        rst = 1;
        model_reset();
        #1;
        chk("t5_rst_req", irq_req, 0);
        chk("t5_rst_pend", pending, 0);
        tick();
        rst = 0;

        // 6: ack together with eret, and a re-edge landing on the ack edge
        do_reset();
        int_en = 1;
        pulse(3'b001); wait_req(10); ack();
        pulse(3'b100); wait_req(10);
        irq_ack = 1; eret = 1; tick(); irq_ack = 0; eret = 0;
        chk("t6_svc_swap", in_service, 3'b100);
        chk("t6_pend", pending, 3'b000);
        ret();
        pulse(3'b001); wait_req(10);
        irq_type = 3'b001;
        ticks(2);
        ack();
        chk("t6_pend_kept", pending, 3'b001);
        chk("t6_svc0", in_service, 3'b001);
        irq_type = 0;
        tick();
        chk("t6_no_self", irq_req, 0);
        ret();
        wait_req(10);
        chk("t6_id0", irq_id, 0);

        // randomized run
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            if (hold == 0) begin
                irq_type = 3'($urandom_range(0, 7));
                hold     = $urandom_range(3, 8);
            end
            hold--;
            int_en  = ($urandom % 8) != 0;
            irq_ack = ($urandom % 3) == 0;
            eret    = ($urandom % 8) == 0;
            if (($urandom % 400) == 0) begin
                rst = 1;
                model_reset();
            end
            tick();
            rst = 0;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
